// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags, commit-to-read bypass and
// checkpointed busy/tag snapshots for mispredict recovery.
module rename_reg_file #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int IDX_W    = 5,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     commit_valid,
  input  logic [IDX_W-1:0]         commit_idx,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [XLEN-1:0]          commit_val,
  input  logic                     ren_valid,
  input  logic [IDX_W-1:0]         ren_idx,
  input  logic [TAG_W-1:0]         ren_tag,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  output logic [NUM_RD*XLEN-1:0]   rd_val,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic                     ckpt_save,
  input  logic [CKPT_W-1:0]        ckpt_save_id,
  input  logic                     ckpt_restore,
  input  logic [CKPT_W-1:0]        ckpt_restore_id
);

  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

  // Live state
  logic [XLEN-1:0]  regs_r [NREG];
  logic [NREG-1:0]  busy_r;
  logic [TAG_W-1:0] tag_r  [NREG];

  // Checkpoint slots (busy/tag only; register values are never snapshotted)
  logic [NREG-1:0]  snap_busy_r [NUM_CKPT];
  logic [TAG_W-1:0] snap_tag_r  [NUM_CKPT][NREG];

  // Next-state
  logic [NREG-1:0]  busy_s;
  logic [TAG_W-1:0] tag_s       [NREG];
  logic [NREG-1:0]  snap_busy_s [NUM_CKPT];
  logic [TAG_W-1:0] snap_tag_s  [NUM_CKPT][NREG];

  logic commit_ok_s;
  logic ren_ok_s;

  // Writes aimed at x0 are dropped at the source.
  assign commit_ok_s = commit_valid && (commit_idx != ZERO_IDX);
  assign ren_ok_s    = ren_valid && (ren_idx != ZERO_IDX);

  // Combinational read ports: x0 forced to zero, then commit bypass, then table.
  always_comb begin
    rd_val  = {(NUM_RD*XLEN){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    rd_tag  = {(NUM_RD*TAG_W){1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      logic [IDX_W-1:0] idx_s;
      idx_s = rd_idx[k*IDX_W +: IDX_W];
      if (idx_s == ZERO_IDX) begin
        rd_val[k*XLEN +: XLEN]   = {XLEN{1'b0}};
        rd_busy[k]               = 1'b0;
        rd_tag[k*TAG_W +: TAG_W] = {TAG_W{1'b0}};
      end else if (commit_valid && (commit_idx == idx_s) && busy_r[idx_s]
                   && (tag_r[idx_s] == commit_tag)) begin
        // The retiring producer's value is forwarded in the same cycle.
        rd_val[k*XLEN +: XLEN]   = commit_val;
        rd_busy[k]               = 1'b0;
        rd_tag[k*TAG_W +: TAG_W] = {TAG_W{1'b0}};
      end else begin
        rd_val[k*XLEN +: XLEN]   = regs_r[idx_s];
        rd_busy[k]               = busy_r[idx_s];
        rd_tag[k*TAG_W +: TAG_W] = busy_r[idx_s] ? tag_r[idx_s] : {TAG_W{1'b0}};
      end
    end
  end

  // Next busy/tag table and snapshots: flush > restore > commit/rename/save.
  always_comb begin
    busy_s      = busy_r;
    tag_s       = tag_r;
    snap_busy_s = snap_busy_r;
    snap_tag_s  = snap_tag_r;

    if (flush_in) begin
      busy_s = {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        tag_s[i] = {TAG_W{1'b0}};
      end
      for (int s = 0; s < NUM_CKPT; s++) begin
        snap_busy_s[s] = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
          snap_tag_s[s][i] = {TAG_W{1'b0}};
        end
      end
    end else begin
      if (ckpt_restore) begin
        busy_s = snap_busy_r[ckpt_restore_id];
        tag_s  = snap_tag_r[ckpt_restore_id];
        // A retiring producer must not stay pending in the restored table.
        if (commit_ok_s && (tag_s[commit_idx] == commit_tag)) begin
          busy_s[commit_idx] = 1'b0;
        end else begin
          busy_s = busy_s;
        end
      end else begin
        // A same-cycle rename of the committed register keeps it busy.
        if (commit_ok_s && (tag_r[commit_idx] == commit_tag)
            && !(ren_ok_s && (ren_idx == commit_idx))) begin
          busy_s[commit_idx] = 1'b0;
        end else begin
          busy_s = busy_s;
        end
        if (ren_ok_s) begin
          busy_s[ren_idx] = 1'b1;
          tag_s[ren_idx]  = ren_tag;
        end else begin
          busy_s = busy_s;
        end
      end

      // Keep every snapshot coherent with retirements so a restore cannot
      // resurrect a dependency on an already retired producer.
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (commit_ok_s && (snap_tag_r[s][commit_idx] == commit_tag)) begin
          snap_busy_s[s][commit_idx] = 1'b0;
        end else begin
          snap_busy_s[s] = snap_busy_s[s];
        end
      end

      // Save captures the post-commit/post-rename table; ignored on restore.
      if (ckpt_save && !ckpt_restore) begin
        snap_busy_s[ckpt_save_id] = busy_s;
        snap_tag_s[ckpt_save_id]  = tag_s;
      end else begin
        snap_busy_s = snap_busy_s;
      end
    end
  end

  // State registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_r <= {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
        tag_r[i]  <= {TAG_W{1'b0}};
      end
      for (int s = 0; s < NUM_CKPT; s++) begin
        snap_busy_r[s] <= {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
          snap_tag_r[s][i] <= {TAG_W{1'b0}};
        end
      end
    end else if (rdy_in) begin
      busy_r      <= busy_s;
      tag_r       <= tag_s;
      snap_busy_r <= snap_busy_s;
      snap_tag_r  <= snap_tag_s;
      // Commit values land in the register file in every mode, flush included.
      if (commit_ok_s) begin
        regs_r[commit_idx] <= commit_val;
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file.
module tb_rename_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        commit_valid;
  logic [4:0]  commit_idx;
  logic [3:0]  commit_tag;
  logic [31:0] commit_val;
  logic        ren_valid;
  logic [4:0]  ren_idx;
  logic [3:0]  ren_tag;
  logic [9:0]  rd_idx;
  logic [63:0] rd_val;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic        ckpt_save;
  logic [1:0]  ckpt_save_id;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;

  int errors = 0;
  int checks = 0;

  rename_reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_tag(commit_tag),
    .commit_val(commit_val), .ren_valid(ren_valid), .ren_idx(ren_idx), .ren_tag(ren_tag),
    .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle();
    flush_in = 1'b0; commit_valid = 1'b0; ren_valid = 1'b0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0;
    commit_idx = 5'd0; commit_tag = 4'd0; commit_val = 32'd0;
    ren_idx = 5'd0; ren_tag = 4'd0; ckpt_save_id = 2'd0; ckpt_restore_id = 2'd0;
  endtask

  // Let the next rising edge consume the driven inputs, then settle.
  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
    #1;
  endtask

  task automatic do_ren(input logic [4:0] idx, input logic [3:0] tag);
    ren_valid = 1'b1; ren_idx = idx; ren_tag = tag;
  endtask

  task automatic do_commit(input logic [4:0] idx, input logic [3:0] tag, input logic [31:0] val);
    commit_valid = 1'b1; commit_idx = idx; commit_tag = tag; commit_val = val;
  endtask

  task automatic test_reset();
    rdy_in = 1'b1; idle();
    rst_in = 1'b1;
    rd_idx = {5'd7, 5'd3};
    #1 rst_in = 1'b0;
    #1;
    checks++; if (rd_val !== 64'd0) begin errors++; $display("FAIL reset_val: got %h want 0", rd_val); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", rd_busy); end
    checks++; if (rd_tag !== 8'h00) begin errors++; $display("FAIL reset_tag: got %h want 00", rd_tag); end
    #1 rst_in = 1'b1;
    #1;
  endtask

  task automatic test_rename_commit();
    do_ren(5'd5, 4'd9); tick();
    rd_idx = {5'd7, 5'd5}; #1;
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL ren_busy: got %b want 1", rd_busy[0]); end
    checks++; if (rd_tag[3:0] !== 4'd9) begin errors++; $display("FAIL ren_tag: got %0d want 9", rd_tag[3:0]); end
    do_commit(5'd5, 4'd9, 32'hDEADBEEF); #1;
    checks++; if (rd_val[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_val: got %h want deadbeef", rd_val[31:0]); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL bypass_busy: got %b want 00", rd_busy); end
    checks++; if (rd_tag[3:0] !== 4'd0) begin errors++; $display("FAIL bypass_tag: got %0d want 0", rd_tag[3:0]); end
    checks++; if (rd_val[63:32] !== 32'd0) begin errors++; $display("FAIL bypass_other_port: got %h want 0", rd_val[63:32]); end
    tick();
    checks++; if (rd_val[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_reg_val: got %h want deadbeef", rd_val[31:0]); end
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL commit_reg_busy: got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_stale_commit();
    do_ren(5'd5, 4'd9); tick();
    do_ren(5'd5, 4'd11); tick();
    rd_idx = {5'd0, 5'd5};
    do_commit(5'd5, 4'd9, 32'h10); #1;
    checks++; if (rd_val[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b1) begin errors++; $display("FAIL stale_no_bypass: got val %h busy %b want deadbeef 1", rd_val[31:0], rd_busy[0]); end
    tick();
    checks++; if (rd_val[31:0] !== 32'h10) begin errors++; $display("FAIL stale_val: got %h want 10", rd_val[31:0]); end
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL stale_busy: got %b want 1", rd_busy[0]); end
    checks++; if (rd_tag[3:0] !== 4'd11) begin errors++; $display("FAIL stale_tag: got %0d want 11", rd_tag[3:0]); end
  endtask

  task automatic test_commit_rename_same();
    do_ren(5'd6, 4'd2); tick();
    rd_idx = {5'd0, 5'd6};
    do_commit(5'd6, 4'd2, 32'h55); do_ren(5'd6, 4'd3); #1;
    checks++; if (rd_val[31:0] !== 32'h55 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL same_bypass: got val %h busy %b want 55 0", rd_val[31:0], rd_busy[0]); end
    tick();
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", rd_busy[0]); end
    checks++; if (rd_tag[3:0] !== 4'd3) begin errors++; $display("FAIL same_tag: got %0d want 3", rd_tag[3:0]); end
    checks++; if (rd_val[31:0] !== 32'h55) begin errors++; $display("FAIL same_val: got %h want 55", rd_val[31:0]); end
  endtask

  task automatic test_checkpoint();
    do_ren(5'd8, 4'd4); tick();
    ckpt_save = 1'b1; ckpt_save_id = 2'd1; tick();
    do_ren(5'd9, 4'd5); tick();
    do_commit(5'd8, 4'd4, 32'd7); tick();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; tick();
    rd_idx = {5'd9, 5'd8}; #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL ckpt_x8_busy: got %b want 0", rd_busy[0]); end
    checks++; if (rd_val[31:0] !== 32'd7) begin errors++; $display("FAIL ckpt_x8_val: got %h want 7", rd_val[31:0]); end
    checks++; if (rd_busy[1] !== 1'b0 || rd_tag[7:4] !== 4'd0) begin errors++; $display("FAIL ckpt_x9: got busy %b tag %0d want 0 0", rd_busy[1], rd_tag[7:4]); end
    rd_idx = {5'd6, 5'd5}; #1;
    checks++; if (rd_busy !== 2'b11 || rd_tag !== {4'd3, 4'd11}) begin errors++; $display("FAIL ckpt_kept: got busy %b tag %h want 11 3b", rd_busy, rd_tag); end
    // Commit in a restore cycle clears the matching restored entry.
    do_ren(5'd12, 4'd6); tick();
    ckpt_save = 1'b1; ckpt_save_id = 2'd2; tick();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; do_commit(5'd12, 4'd6, 32'h99); tick();
    rd_idx = {5'd0, 5'd12}; #1;
    checks++; if (rd_busy[0] !== 1'b0 || rd_val[31:0] !== 32'h99) begin errors++; $display("FAIL restore_commit: got busy %b val %h want 0 99", rd_busy[0], rd_val[31:0]); end
    // Same-id save and restore: restore of an unsaved slot wins, save dropped.
    do_ren(5'd10, 4'd7); tick();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd3; ckpt_save = 1'b1; ckpt_save_id = 2'd3; tick();
    rd_idx = {5'd5, 5'd10}; #1;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL unsaved_restore: got %b want 00", rd_busy); end
    do_ren(5'd10, 4'd1); tick();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd3; tick();
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL save_ignored: got %b want 0", rd_busy[0]); end
  endtask

  task automatic test_flush();
    for (int i = 1; i < 32; i++) begin
      do_ren(i[4:0], i[3:0]); tick();
    end
    ckpt_save = 1'b1; ckpt_save_id = 2'd0; tick();
    rd_idx = {5'd31, 5'd1}; #1;
    checks++; if (rd_busy !== 2'b11 || rd_tag !== {4'd15, 4'd1}) begin errors++; $display("FAIL pre_flush: got busy %b tag %h want 11 f1", rd_busy, rd_tag); end
    flush_in = 1'b1; tick();
    for (int i = 1; i < 32; i++) begin
      rd_idx = {5'd0, i[4:0]}; #1;
      checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL flush_busy_x%0d: got %b want 0", i, rd_busy[0]); end
    end
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; tick();
    rd_idx = {5'd31, 5'd1}; #1;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_ckpt: got %b want 00", rd_busy); end
  endtask

  task automatic test_x0();
    rd_idx = {5'd0, 5'd0};
    do_commit(5'd0, 4'd0, 32'hFF); #1;
    checks++; if (rd_val !== 64'd0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rd_val); end
    tick();
    do_ren(5'd0, 4'd3); tick();
    checks++; if (rd_val !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'h00) begin errors++; $display("FAIL x0_read: got val %h busy %b tag %h want 0", rd_val, rd_busy, rd_tag); end
  endtask

  task automatic test_rdy();
    rdy_in = 1'b0;
    do_ren(5'd2, 4'd5); do_commit(5'd6, 4'd3, 32'h77); tick();
    rdy_in = 1'b1;
    rd_idx = {5'd6, 5'd2}; #1;
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL rdy_busy: got %b want 00", rd_busy); end
    checks++; if (rd_val[63:32] !== 32'h55) begin errors++; $display("FAIL rdy_val: got %h want 55", rd_val[63:32]); end
  endtask

  task automatic test_async_reset();
    do_ren(5'd2, 4'd5); tick();
    rd_idx = {5'd6, 5'd2};
    #1 rst_in = 1'b0;
    #1;
    checks++; if (rd_val !== 64'd0 || rd_busy !== 2'b00) begin errors++; $display("FAIL async_reset: got val %h busy %b want 0 00", rd_val, rd_busy); end
    rst_in = 1'b1;
    #1;
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_commit_rename_same();
    test_checkpoint();
    test_flush();
    test_x0();
    test_rdy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
